// File: rtl/bp_update_queue_pkg.sv
// Shared types for branch-resolution records passed from execute
// to the branch history table update path.
package bp_update_queue_pkg;

    typedef logic [31:0] addr_t;

    typedef struct packed {
        addr_t pc;
        addr_t dest;
        logic  taken;
        logic  pred_hit;
        logic  pred_taken;
        addr_t pred_dest;
    } bp_update_t;

    function automatic logic is_mispredict(input bp_update_t r);
        return (r.pred_taken != r.taken)
            || (r.taken && !r.pred_hit)
            || (r.taken && (r.pred_dest != r.dest));
    endfunction

endpackage

// File: rtl/bp_fifo.sv
// Generic synchronous FIFO; head entry is read combinationally,
// no write-through bypass.
module bp_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  T     wdata,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    T              mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (!push && pop)
                count <= count - CW'(1);
        end
    end

    // Payload storage is never cleared; validity lives in count.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/bp_update_queue.sv
// Decouples resolved branches from the BHT update port and keeps
// drained-branch and misprediction statistics.
module bp_update_queue
    import bp_update_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  addr_t       in_pc,
    input  addr_t       in_dest,
    input  logic        in_taken,
    input  logic        in_pred_hit,
    input  logic        in_pred_taken,
    input  addr_t       in_pred_dest,
    output logic        out_write,
    input  logic        out_ready,
    output addr_t       out_pc,
    output addr_t       out_dest,
    output logic        out_taken,
    output logic        out_mispredict,
    output logic        empty,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    bp_update_t in_rec;
    bp_update_t head;
    logic       full;
    logic       push;
    logic       pop;

    assign in_rec = '{
        pc:         in_pc,
        dest:       in_dest,
        taken:      in_taken,
        pred_hit:   in_pred_hit,
        pred_taken: in_pred_taken,
        pred_dest:  in_pred_dest
    };

    assign out_write = !reset && !empty;
    assign pop       = out_write && out_ready;
    assign in_ready  = !reset && (!full || pop);
    assign push      = in_valid && in_ready;

    bp_fifo #(
        .DEPTH (DEPTH),
        .T     (bp_update_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (in_rec),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign out_pc         = head.pc;
    assign out_dest       = head.dest;
    assign out_taken      = head.taken;
    assign out_mispredict = out_write && is_mispredict(head);

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (pop) begin
            branch_count     <= branch_count + 32'd1;
            mispredict_count <= mispredict_count + 32'(out_mispredict);
        end
    end

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed bench for bp_update_queue: ordering, backpressure,
// misprediction classification, reset and counter wrap.
module tb_bp_update_queue;
    import bp_update_queue_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    addr_t       in_pc = '0;
    addr_t       in_dest = '0;
    logic        in_taken = 1'b0;
    logic        in_pred_hit = 1'b0;
    logic        in_pred_taken = 1'b0;
    addr_t       in_pred_dest = '0;
    logic        out_write;
    logic        out_ready = 1'b0;
    addr_t       out_pc;
    addr_t       out_dest;
    logic        out_taken;
    logic        out_mispredict;
    logic        empty;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bp_update_queue #(.DEPTH(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_pc            (in_pc),
        .in_dest          (in_dest),
        .in_taken         (in_taken),
        .in_pred_hit      (in_pred_hit),
        .in_pred_taken    (in_pred_taken),
        .in_pred_dest     (in_pred_dest),
        .out_write        (out_write),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_dest         (out_dest),
        .out_taken        (out_taken),
        .out_mispredict   (out_mispredict),
        .empty            (empty),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bp_update_t r);
        in_pc         = r.pc;
        in_dest       = r.dest;
        in_taken      = r.taken;
        in_pred_hit   = r.pred_hit;
        in_pred_taken = r.pred_taken;
        in_pred_dest  = r.pred_dest;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Correctly predicted record; direction varies with pc bit 2.
    function automatic bp_update_t mk(input addr_t pc);
        bp_update_t r;
        r.pc         = pc;
        r.dest       = pc + 32'h40;
        r.taken      = pc[2];
        r.pred_hit   = 1'b1;
        r.pred_taken = pc[2];
        r.pred_dest  = pc + 32'h40;
        return r;
    endfunction

    bp_update_t mp_vec [5];
    logic       mp_exp [5];

    initial begin
        mp_vec[0] = '{32'h1000, 32'h2000, 1'b1, 1'b1, 1'b0, 32'h2000};
        mp_vec[1] = '{32'h1004, 32'h2004, 1'b1, 1'b0, 1'b1, 32'h2004};
        mp_vec[2] = '{32'h1008, 32'h2008, 1'b1, 1'b1, 1'b1, 32'h3008};
        mp_vec[3] = '{32'h100c, 32'h200c, 1'b0, 1'b1, 1'b1, 32'h200c};
        mp_vec[4] = '{32'h1010, 32'h2010, 1'b0, 1'b0, 1'b0, 32'hdeadbeef};
        mp_exp    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // reset gating, then idle
        out_ready = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_write", out_write, 0);
        check("rst_mispredict", out_mispredict, 0);
        reset     = 1'b0;
        out_ready = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);
        check("idle_out_write", out_write, 0);
        check("idle_empty", empty, 1);
        check("idle_bcnt", branch_count, 0);
        check("idle_mcnt", mispredict_count, 0);

        // single push, 1-cycle latency, presented for one cycle
        out_ready = 1'b1;
        drive('{32'h8000_0010, 32'h8000_0100, 1'b1, 1'b1, 1'b1,
                32'h8000_0100});
        in_valid = 1'b1;
        #1;
        check("one_in_ready", in_ready, 1);
        check("one_no_bypass", out_write, 0);
        tick();
        in_valid = 1'b0;
        #1;
        check("one_write", out_write, 1);
        check("one_pc", out_pc, 32'h8000_0010);
        check("one_dest", out_dest, 32'h8000_0100);
        check("one_taken", out_taken, 1);
        check("one_mp", out_mispredict, 0);
        check("one_bcnt_pre", branch_count, 0);
        tick();
        check("one_write_off", out_write, 0);
        check("one_empty", empty, 1);
        check("one_bcnt", branch_count, 1);
        check("one_mcnt", mispredict_count, 0);

        // backpressure: 5th record held while full
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(mk(32'h100 + 32'(4 * i)));
            in_valid = 1'b1;
            tick();
        end
        drive(mk(32'h110));
        #1;
        check("full_in_ready", in_ready, 0);
        tick();
        check("full_hold_ready", in_ready, 0);
        check("full_hold_pc", out_pc, 32'h100);
        out_ready = 1'b1;
        #1;
        check("full_pop_ready", in_ready, 1);
        check("full_head0", out_pc, 32'h100);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 5; k++) begin
            #1;
            check("drain_write", out_write, 1);
            check("drain_pc", out_pc, 32'h100 + 32'(4 * k));
            check("drain_taken", out_taken, 32'(k[0]));
            tick();
        end
        check("drain_empty", empty, 1);
        check("drain_bcnt", branch_count, 5);

        // full with simultaneous push/pop across pointer wrap
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(mk(32'h200 + 32'(4 * i)));
            in_valid = 1'b1;
            tick();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            drive(mk(32'h200 + 32'(4 * (c + 4))));
            #1;
            check("pp_in_ready", in_ready, 1);
            check("pp_pc", out_pc, 32'h200 + 32'(4 * c));
            tick();
        end
        out_ready = 1'b0;
        drive(mk(32'h230));
        #1;
        check("pp_still_full", in_ready, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 8; k < 12; k++) begin
            #1;
            check("pp_drain_pc", out_pc, 32'h200 + 32'(4 * k));
            tick();
        end
        check("pp_empty", empty, 1);
        check("pp_bcnt", branch_count, 12);

        // misprediction classification
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(mp_vec[i]);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            #1;
            check("mp_write", out_write, 1);
            check($sformatf("mp_case%0d", i), out_mispredict,
                  32'(mp_exp[i]));
            tick();
        end
        check("mp_mcnt", mispredict_count, 4);
        check("mp_bcnt", branch_count, 5);

        // reset with queued records discards them
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(mk(32'h300 + 32'(4 * i)));
            in_valid = 1'b1;
            tick();
        end
        reset     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("mrst_in_ready", in_ready, 0);
        check("mrst_out_write", out_write, 0);
        check("mrst_mp", out_mispredict, 0);
        tick();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("mrst_empty", empty, 1);
        check("mrst_write", out_write, 0);
        check("mrst_bcnt", branch_count, 0);
        check("mrst_mcnt", mispredict_count, 0);

        // counter wrap on a mispredicted pop
        drive(mp_vec[0]);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        force dut.branch_count = 32'hffff_ffff;
        force dut.mispredict_count = 32'hffff_ffff;
        #1;
        release dut.branch_count;
        release dut.mispredict_count;
        out_ready = 1'b1;
        #1;
        check("wrap_pre", branch_count, 32'hffff_ffff);
        tick();
        check("wrap_bcnt", branch_count, 0);
        check("wrap_mcnt", mispredict_count, 0);
        check("wrap_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bp_update_queue.md
# bp_update_queue

Decoupling FIFO between the execute stage and the branch history table's update port. Captures each resolved branch: PC, actual target, taken flag, and the prediction made for it at fetch. Drains one record per cycle into the table's write port (is_write / executed_branch_pc / dest_pc / is_taken) whenever the table accepts updates. Classifies each drained record as correctly or wrongly predicted and keeps wrapping statistics counters.

## Interface
- DEPTH, 4, number of queue entries; power of two, ≥2
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  execute offers a resolved branch
- in_ready  out  1  queue accepts the offer this cycle
- in_pc  in  32  branch PC (addr_t)
- in_dest  in  32  actual branch target
- in_taken  in  1  branch actually taken
- in_pred_hit  in  1  table hit at fetch
- in_pred_taken  in  1  predicted direction at fetch
- in_pred_dest  in  32  predicted target at fetch
- out_write  out  1  record presented to table (drives is_write)
- out_ready  in  1  table accepts an update this cycle; low during table init
- out_pc  out  32  drives executed_branch_pc
- out_dest  out  32  drives dest_pc
- out_taken  out  1  drives is_taken
- out_mispredict  out  1  head record was mispredicted; valid with out_write
- empty  out  1  queue holds no records
- branch_count  out  32  records drained since reset
- mispredict_count  out  32  mispredicted records drained since reset

## Operation
- Storage: DEPTH-entry circular buffer. Read pointer, write pointer, and occupancy counter, each $clog2(DEPTH)+1 bits wide as needed. Pointers wrap modulo DEPTH.
- Push when in_valid && in_ready; the record is written at the write pointer.
- Pop when out_write && out_ready; the read pointer advances.
- in_ready = !reset && (count < DEPTH || pop).
  - A simultaneous push and pop is allowed when full.
  - When full with no pop, in_ready is low.
  - Execute holds the record, and in_valid stays asserted, until accepted.
- Simultaneous push and pop at any occupancy: count is unchanged, both pointers advance.
- Push into an empty queue: the record is not bypassed; it appears on out_* the next cycle.
- out_write = !reset && count != 0. out_pc, out_dest and out_taken come straight from the head entry.
- out_mispredict is computed combinationally from the head entry. It is 1 iff any of:
  - pred_taken != taken
  - taken && !pred_hit
  - taken && pred_dest != dest
- Counters update only on pop:
  - branch_count += 1.
  - mispredict_count += out_mispredict.
  - Both are 32-bit and wrap from 0xFFFF_FFFF to 0.
- empty = (count == 0).
- Reset:
  - Pointers, count and both counters go to 0.
  - in_ready = 0, out_write = 0, empty = 1, out_mispredict = 0.
  - Entry payloads are not cleared.
  - Reset mid-operation discards all queued records, with no pop and no counter update that cycle. Inputs are ignored while reset is high.

## Timing
- Push-to-presentation latency: 1 cycle (write at edge N, visible on out_* after edge N).
- Throughput: 1 push and 1 pop per cycle, sustained.
- The table samples the update at the same edge as the pop. out_* must be stable from the start of the cycle: they depend only on state, never on in_*.
- in_ready depends combinationally on out_ready (via pop). There is no path from in_valid to in_ready or out_*.
- Counters reflect a pop one cycle after the pop edge.
- out_ready low for any length: records held, no loss, no duplication.

## Structure
- Shared package: addr_t (32-bit) and a packed bp_update_t record {pc, dest, taken, pred_hit, pred_taken, pred_dest}. The same type is used by the execute stage.
- One natural sub-module: bp_fifo, a generic synchronous FIFO parameterised by DEPTH and element type. It owns the pointers and count and is reusable elsewhere.
- The top level adds the misprediction compare, the counters, and the reset gating of in_ready and out_write.

## Test plan
- Reset then idle: in_ready=1, out_write=0, empty=1, both counters 0 from the first cycle after reset drops.
- Single push {pc=0x8000_0010, dest=0x8000_0100, taken=1, pred_hit=1, pred_taken=1, pred_dest=0x8000_0100} with out_ready=1 → out_write high for exactly 1 cycle, out_mispredict=0, then branch_count=1, mispredict_count=0.
- out_ready=0, push 5 records, DEPTH=4 → the 5th is held (in_ready=0). Raise out_ready → all 5 drain in push order, no gaps, branch_count=5.
- Full queue with simultaneous push and pop for 8 cycles → in_ready=1 throughout, count stays 4, drained order is preserved across pointer wrap.
- Misprediction cases, each drained once:
  - taken=1, pred_taken=0
  - taken=1, pred_hit=0
  - taken=1, pred_dest≠dest
  - taken=0, pred_taken=1
  - taken=0, pred_taken=0, pred_dest garbage
  - Result: mispredict_count=4, branch_count=5.
- Assert reset with 3 queued records → next cycle empty=1, out_write=0, counters 0. Preload branch_count=0xFFFF_FFFF via force, one pop → wraps to 0.
